// File: rtl/imem_fetch_responder_pkg.sv
// Shared fetch definitions: instruction width, NOP word, fault encoding and response record.
// No logic; latency and backpressure behaviour live in the modules that import it.
package imem_fetch_responder_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      FAULT_NONE = 1'b0,
      FAULT_ADDR = 1'b1
   } fetch_fault_e;

   typedef struct packed {
      fetch_fault_e    fault;
      logic [XLEN-1:0] instr;
   } fetch_rsp_t;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous FIFO, read data is the head entry (zero-latency show-ahead).
// Push is refused when full unless a pop happens on the same edge; pop on empty is ignored.
module resp_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] slot [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointers wrap at DEPTH, so non-power-of-two depths are fine.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign pop_dat = slot[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            slot[i] <= '0;
         end
      end else begin
         if (do_push) begin
            slot[wr_ptr] <= push_dat;
            wr_ptr       <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (do_push && !do_pop) begin
            count <= count + CW'(1);
         end else if (!do_push && do_pop) begin
            count <= count - CW'(1);
         end
      end
   end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction memory responder: read at accept, response visible LATENCY cycles later, in order.
// Backpressure by credit: req_ready drops once QDEPTH requests are outstanding and none is popping.
module imem_fetch_responder
   import imem_fetch_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 1,
   parameter int QDEPTH      = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [XLEN-1:0] req_addr,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_instr,
   output logic            rsp_fault,
   input  logic            ld_we,
   input  logic [XLEN-1:0] ld_addr,
   input  logic [XLEN-1:0] ld_data
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(QDEPTH + 1);

   logic [XLEN-1:0] mem [DEPTH_WORDS];
   logic [CW-1:0]   outstanding;
   logic            req_fire;
   logic            rsp_fire;
   logic            req_bad;
   logic            ld_ok;
   fetch_rsp_t      rd_rsp;
   fetch_rsp_t      push_rsp;
   fetch_rsp_t      head_rsp;
   logic            push_vld;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;

   assign req_bad   = (req_addr[1:0] != 2'b00) || (req_addr[XLEN-1:AW+2] != '0);
   assign ld_ok     = (ld_addr[1:0] == 2'b00) && (ld_addr[XLEN-1:AW+2] == '0);
   assign rsp_fire  = rsp_valid & rsp_ready;
   assign req_ready = (outstanding < CW'(QDEPTH)) || rsp_fire;
   assign req_fire  = req_valid & req_ready;

   always_comb begin
      rd_rsp.fault = FAULT_NONE;
      rd_rsp.instr = mem[req_addr[AW+1:2]];
      if (req_bad) begin
         rd_rsp.fault = FAULT_ADDR;
         rd_rsp.instr = NOP_INSTR;
      end
   end

   // Not reset: the program image survives a core reset. Read above sees the pre-edge value.
   always_ff @(posedge clk) begin
      if (ld_we && ld_ok) begin
         mem[ld_addr[AW+1:2]] <= ld_data;
      end
   end

   generate
      if (LATENCY == 1) begin : g_direct
         assign push_vld = req_fire;
         assign push_rsp = rd_rsp;
      end else begin : g_pipe
         logic       pipe_vld [LATENCY-1];
         fetch_rsp_t pipe_rsp [LATENCY-1];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < LATENCY - 1; i++) begin
                  pipe_vld[i] <= 1'b0;
                  pipe_rsp[i] <= '0;
               end
            end else begin
               pipe_vld[0] <= req_fire;
               pipe_rsp[0] <= rd_rsp;
               for (int i = 1; i < LATENCY - 1; i++) begin
                  pipe_vld[i] <= pipe_vld[i-1];
                  pipe_rsp[i] <= pipe_rsp[i-1];
               end
            end
         end

         assign push_vld = pipe_vld[LATENCY-2];
         assign push_rsp = pipe_rsp[LATENCY-2];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= '0;
      end else if (req_fire && !rsp_fire) begin
         outstanding <= outstanding + CW'(1);
      end else if (!req_fire && rsp_fire) begin
         outstanding <= outstanding - CW'(1);
      end
   end

   resp_fifo #(
      .WIDTH ($bits(fetch_rsp_t)),
      .DEPTH (QDEPTH),
      .CW    (CW)
   ) u_resp_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push_vld),
      .push_dat (push_rsp),
      .pop      (rsp_ready),
      .pop_dat  (head_rsp),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   assign rsp_valid = ~fifo_empty;
   assign rsp_instr = head_rsp.instr;
   assign rsp_fault = (head_rsp.fault == FAULT_ADDR);

   // The credit count guarantees the queue never sees a push it cannot take.
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(push_vld && fifo_full && !rsp_fire));
   a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
      fifo_count <= outstanding);

endmodule
